// File: rtl/eddsa_pkg.sv
// -----------------------------------------------------------------------------
// eddsa_pkg
// Shared definitions for the EdDSA core sequencer: FSM state encoding,
// operation mode codes and the block qualifier codes driven to the core.
// -----------------------------------------------------------------------------
package eddsa_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CRST    = 3'd1,
      FETCH   = 3'd2,
      PRESENT = 3'd3,
      RUN     = 3'd4,
      DONE    = 3'd5,
      FAIL    = 3'd6
   } state_t;

   localparam logic [1:0] MODE_ILLEGAL = 2'b00;
   localparam logic [1:0] MODE_SIGN    = 2'b01;
   localparam logic [1:0] MODE_VERIFY  = 2'b10;
   localparam logic [1:0] MODE_PUBKEY  = 2'b11;

   localparam logic [1:0] BV_NONE = 2'b00;
   localparam logic [1:0] BV_MID  = 2'b01;
   localparam logic [1:0] BV_LAST = 2'b11;

   // Sign and verify stream message blocks into the core; pubkey-gen does not.
   function automatic logic mode_needs_msg(input logic [1:0] m);
      return (m == MODE_SIGN) || (m == MODE_VERIFY);
   endfunction

endpackage

// File: rtl/eddsa_wdog.sv
// -----------------------------------------------------------------------------
// eddsa_wdog
// Per-state watchdog for the EdDSA sequencer. Counts up while enabled and is
// zeroed by i_clear (driven on every FSM state change).
//
// Ports
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   i_clear   : zero the counter this cycle (takes priority over i_enable)
//   i_enable  : count this cycle
//   o_expired : the current cycle's increment would land on all-ones
// -----------------------------------------------------------------------------
module eddsa_wdog #(
   parameter int W = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   // all-ones minus one: flagging here lets the FSM leave on the same edge the
   // counter would reach all-ones, so a state times out after 2**W-1 cycles.
   localparam logic [W-1:0] CNT_TERM = {{(W-1){1'b1}}, 1'b0};

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_expired = i_enable && (r_cnt == CNT_TERM);

endmodule

// File: rtl/eddsa_seq.sv
// -----------------------------------------------------------------------------
// eddsa_seq
// Sequencer wrapping an EdDSA core: resets the core, streams message blocks
// into it with a block-ready/block-valid handshake, waits for the result and
// reports done/err/tmo. Abort, a per-state watchdog and illegal-mode
// detection are handled here.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; only state with busy=0
// CRST    | core_rst held for RST_CYC cycles
// FETCH   | waiting for core_block_ready and msg_valid together
// PRESENT | block registered on core_message, qualifier driven
// RUN     | waiting for core_valid / core_error
// DONE    | success, done pulse follows
// FAIL    | error or timeout, err set and done pulse follows
//
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   start, mode, abort          : operation request / select / cancel
//   busy, done, err, tmo        : status (done is a one-cycle pulse)
//   msg_valid/last/data         : upstream block offer
//   msg_ready                   : one-cycle upstream accept strobe
//   core_rst, core_sel          : core reset and operation select
//   core_block_valid, core_message : block qualifier and registered block
//   core_block_ready, core_valid, core_error : core handshake / result
// -----------------------------------------------------------------------------
module eddsa_seq
   import eddsa_pkg::*;
#(
   parameter int SIZE_BLOCK = 1024,
   parameter int TO_W       = 24,
   parameter int RST_CYC    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  tmo,
   input  logic                  msg_valid,
   input  logic                  msg_last,
   input  logic [SIZE_BLOCK-1:0] msg_data,
   output logic                  msg_ready,
   output logic                  core_rst,
   output logic [1:0]            core_sel,
   output logic [1:0]            core_block_valid,
   output logic [SIZE_BLOCK-1:0] core_message,
   input  logic                  core_block_ready,
   input  logic                  core_valid,
   input  logic                  core_error
);

   localparam int CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [CW-1:0] CRST_LOAD = CW'(RST_CYC - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [1:0]            r_core_sel;
   logic [SIZE_BLOCK-1:0] r_core_msg;
   logic                  r_last;
   logic [CW-1:0]         r_crst_cnt;
   logic                  r_done;
   logic                  r_err;
   logic                  r_tmo;
   logic                  r_rst_pulse;

   logic w_active;
   logic w_abort;
   logic w_expired;
   logic w_clear;
   logic w_start_ok;
   logic w_accept;

   assign w_active   = (r_state != IDLE);
   assign w_abort    = w_active && abort;
   assign w_start_ok = (r_state == IDLE) && start;
   // Abort and timeout win over the block handshake so a block is never
   // consumed on a cycle the FSM is leaving FETCH for another reason.
   assign w_accept   = (r_state == FETCH) && core_block_ready && msg_valid
                       && !w_abort && !w_expired;
   assign w_clear    = (w_state_nxt != r_state);

   eddsa_wdog #(
      .W (TO_W)
   ) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_clear),
      .i_enable  (w_active),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_abort) begin
         w_state_nxt = IDLE;
      end else if (w_expired) begin
         w_state_nxt = FAIL;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  w_state_nxt = (mode == MODE_ILLEGAL) ? FAIL : CRST;
               end
            end
            CRST: begin
               if (r_crst_cnt == '0) begin
                  w_state_nxt = mode_needs_msg(r_core_sel) ? FETCH : RUN;
               end
            end
            FETCH: begin
               if (core_block_ready && msg_valid) begin
                  w_state_nxt = PRESENT;
               end
            end
            PRESENT: begin
               if (!core_block_ready) begin
                  w_state_nxt = r_last ? RUN : FETCH;
               end
            end
            RUN: begin
               if (core_error) begin
                  w_state_nxt = FAIL;
               end else if (core_valid) begin
                  w_state_nxt = DONE;
               end
            end
            DONE:    w_state_nxt = IDLE;
            FAIL:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_core_sel  <= MODE_ILLEGAL;
         r_core_msg  <= '0;
         r_last      <= 1'b0;
         r_crst_cnt  <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_tmo       <= 1'b0;
         r_rst_pulse <= 1'b1;
      end else begin
         // r_rst_pulse carries the reset-time and abort-time core reset;
         // CRST drives core_rst directly from the state.
         r_rst_pulse <= w_abort;
         r_done      <= ((r_state == DONE) || (r_state == FAIL)) && !w_abort;

         if (w_start_ok && (mode != MODE_ILLEGAL)) begin
            r_core_sel <= mode;
            r_crst_cnt <= CRST_LOAD;
         end else if ((r_state == CRST) && (r_crst_cnt != '0)) begin
            r_crst_cnt <= r_crst_cnt - CW'(1);
         end

         if (w_accept) begin
            r_core_msg <= msg_data;
            r_last     <= msg_last;
         end

         if (w_start_ok) begin
            r_err <= 1'b0;
            r_tmo <= 1'b0;
         end else begin
            if ((r_state == FAIL) && !w_abort) begin
               r_err <= 1'b1;
            end
            if (w_expired && !w_abort) begin
               r_tmo <= 1'b1;
            end
         end
      end
   end

   assign busy             = w_active;
   assign done             = r_done;
   assign err              = r_err;
   assign tmo              = r_tmo;
   assign msg_ready        = w_accept;
   assign core_rst         = (r_state == CRST) || r_rst_pulse;
   assign core_sel         = r_core_sel;
   assign core_message     = r_core_msg;
   assign core_block_valid = (r_state != PRESENT) ? BV_NONE :
                             (r_last ? BV_LAST : BV_MID);

endmodule
